// File: rtl/soclib_pkg.sv
// Shared register map, status bit positions and FSM state types for the
// RS-232 FIFO UART.
package soclib;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_RXDATA = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_DIV    = 2'd3;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_IDLE     = 1;
    localparam int ST_RX_OVERRUN  = 2;
    localparam int ST_RX_FRAME    = 3;
    localparam int ST_TX_OVERFLOW = 4;

    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; pop_data is valid whenever the FIFO is non-empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int LOG2  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LOG2:0]    count
);
    localparam int unsigned DEPTH = 2 ** LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LOG2-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LOG2:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (LOG2 + 1)'(DEPTH));
        do_pop  = pop && !empty;
        // Push+pop on an empty FIFO passes the word straight through, so the count holds.
        do_push = push && (!full || pop) && !(pop && empty);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (do_pop && !do_push)
            count_d = count_q - 1'b1;
        pop_data = empty ? push_data : mem_q[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/rs232_fifo_uart.sv
// 8N1 UART with TX/RX FIFOs, programmable divisor, sticky error flags and
// optional RTS/CTS hardware flow control.
module rs232_fifo_uart
    import soclib::*;
#(
    parameter int FREQ      = 40_000_000,
    parameter int BPS       = 115_200,
    parameter int TX_LOG2   = 4,
    parameter int RX_LOG2   = 4,
    parameter int FLOW_CTRL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        ser_txd,
    input  logic        ser_rxd,
    input  logic        ser_ncts,
    output logic        ser_nrts
);
    localparam logic [15:0]      DIV_RESET     = 16'(FREQ / BPS);
    localparam logic [RX_LOG2:0] RX_NRTS_LEVEL = (RX_LOG2 + 1)'(2 ** RX_LOG2 - 1);

    logic rxd_s1_q, rxd_s1_d, rxd_s2_q, rxd_s2_d;
    logic ncts_s1_q, ncts_s1_d, ncts_s2_q, ncts_s2_d;
    logic [15:0] div_q, div_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic overrun_q, overrun_d, frame_err_q, frame_err_d, tx_overflow_q, tx_overflow_d;
    logic nrts_q, nrts_d;

    logic             tx_push, tx_start, tx_full, tx_empty;
    logic [7:0]       tx_pop_data;
    logic [TX_LOG2:0] tx_count;
    logic             rx_pop, rx_full, rx_empty;
    logic [7:0]       rx_pop_data;
    logic [RX_LOG2:0] rx_count;
    logic [2:0]       clr;
    logic [31:0]      status;

    tx_state_t   tx_state_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        txd_q;

    rx_state_t   rx_state_q;
    logic [15:0] rx_cnt_q, rx_div_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic        rx_push_q, rx_ferr_q, rxd_prev_q;

    logic unused_ok;
    assign unused_ok = ^{wr_data[31:16], tx_count};

    sync_fifo #(.WIDTH(8), .LOG2(TX_LOG2)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .push_data(wr_data[7:0]),
        .pop(tx_start), .pop_data(tx_pop_data), .full(tx_full), .empty(tx_empty),
        .count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .LOG2(RX_LOG2)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push_q), .push_data(rx_shift_q),
        .pop(rx_pop), .pop_data(rx_pop_data), .full(rx_full), .empty(rx_empty),
        .count(rx_count)
    );

    always_comb begin
        rxd_s1_d  = ser_rxd;
        rxd_s2_d  = rxd_s1_q;
        ncts_s1_d = ser_ncts;
        ncts_s2_d = ncts_s1_q;
        tx_push   = wr && (addr == ADDR_STATUS);
        tx_start  = (tx_state_q == TX_IDLE) && !tx_empty && ((FLOW_CTRL == 0) || !ncts_s2_q);
        rx_pop    = rd && (addr == ADDR_RXDATA) && !rx_empty;
        clr       = (wr && (addr == ADDR_CTRL)) ? wr_data[4:2] : '0;
        // Set terms are OR-ed after the clear so a same-cycle event wins over W1C.
        overrun_d     = (overrun_q & ~clr[0]) | (rx_push_q & rx_full & ~rx_pop);
        frame_err_d   = (frame_err_q & ~clr[1]) | rx_ferr_q;
        tx_overflow_d = (tx_overflow_q & ~clr[2]) | (tx_push & tx_full & ~tx_start);
        div_d  = (wr && (addr == ADDR_DIV)) ? clamp_div(wr_data[15:0]) : div_q;
        nrts_d = (FLOW_CTRL != 0) && (rx_count >= RX_NRTS_LEVEL);

        status                 = '0;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_IDLE]     = tx_empty && (tx_state_q == TX_IDLE);
        status[ST_RX_OVERRUN]  = overrun_q;
        status[ST_RX_FRAME]    = frame_err_q;
        status[ST_TX_OVERFLOW] = tx_overflow_q;

        rd_data_d = '0;
        if (rd) begin
            case (addr)
                ADDR_STATUS: rd_data_d = status;
                ADDR_RXDATA: rd_data_d = {24'd0, rx_empty ? 8'd0 : rx_pop_data};
                ADDR_CTRL:   rd_data_d = 32'(rx_count);
                default:     rd_data_d = {16'd0, div_q};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1_q      <= 1'b1;
            rxd_s2_q      <= 1'b1;
            ncts_s1_q     <= 1'b1;
            ncts_s2_q     <= 1'b1;
            div_q         <= DIV_RESET;
            rd_data_q     <= '0;
            overrun_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            tx_overflow_q <= 1'b0;
            nrts_q        <= 1'b1;
        end else begin
            rxd_s1_q      <= rxd_s1_d;
            rxd_s2_q      <= rxd_s2_d;
            ncts_s1_q     <= ncts_s1_d;
            ncts_s2_q     <= ncts_s2_d;
            div_q         <= div_d;
            rd_data_q     <= rd_data_d;
            overrun_q     <= overrun_d;
            frame_err_q   <= frame_err_d;
            tx_overflow_q <= tx_overflow_d;
            nrts_q        <= nrts_d;
        end
    end

    // Each frame latches the divisor at start so a mid-frame write cannot distort it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_div_q   <= DIV_RESET;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_start) begin
                        tx_state_q <= TX_START;
                        tx_shift_q <= tx_pop_data;
                        tx_div_q   <= div_q;
                        tx_cnt_q   <= '0;
                        txd_q      <= 1'b0;
                    end
                end
                default: begin
                    if (tx_cnt_q == tx_div_q - 16'd1) begin
                        tx_cnt_q <= '0;
                        case (tx_state_q)
                            TX_START: begin
                                tx_state_q <= TX_DATA;
                                tx_bit_q   <= '0;
                                txd_q      <= tx_shift_q[0];
                            end
                            TX_DATA: begin
                                if (tx_bit_q == 3'd7) begin
                                    tx_state_q <= TX_STOP;
                                    txd_q      <= 1'b1;
                                end else begin
                                    tx_bit_q   <= tx_bit_q + 3'd1;
                                    tx_shift_q <= tx_shift_q >> 1;
                                    txd_q      <= tx_shift_q[1];
                                end
                            end
                            default: tx_state_q <= TX_IDLE;
                        endcase
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_div_q   <= DIV_RESET;
            rx_push_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rxd_prev_q <= 1'b1;
        end else begin
            rx_push_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rxd_prev_q <= rxd_s2_q;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rxd_prev_q && !rxd_s2_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                        rx_div_q   <= div_q;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rxd_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == rx_div_q - 16'd1) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7)
                            rx_state_q <= RX_STOP;
                        else
                            rx_bit_q <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == rx_div_q - 16'd1) begin
                        rx_cnt_q <= '0;
                        if (rxd_s2_q) begin
                            rx_push_q  <= 1'b1;
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_ferr_q  <= 1'b1;
                            rx_state_q <= RX_WAIT;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: begin
                    if (rxd_s2_q)
                        rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign ser_txd  = txd_q;
    assign ser_nrts = nrts_q;

endmodule

// File: doc/rs232_fifo_uart.md
RS232_FIFO_UART -- requirements
Module: rs232_fifo_uart

Interface
REQ-001 SHALL have parameter FREQ, default 40_000_000: clock frequency in Hz.
REQ-002 SHALL have parameter BPS, default 115_200: reset baud rate; reset divisor is FREQ/BPS, truncated (347 at defaults).
REQ-003 SHALL have parameter TX_LOG2, default 4: TX FIFO depth is 2**TX_LOG2.
REQ-004 SHALL have parameter RX_LOG2, default 4: RX FIFO depth is 2**RX_LOG2.
REQ-005 SHALL have parameter FLOW_CTRL, default 1: 1 enables RTS/CTS; 0 ignores ser_ncts and drives ser_nrts low.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port addr, input, 2 bits: register select.
REQ-009 SHALL have port rd, input, 1 bit: read strobe.
REQ-010 SHALL have port wr, input, 1 bit: write strobe.
REQ-011 SHALL have port wr_data, input, 32 bits: write data.
REQ-012 SHALL have port rd_data, output, 32 bits: read data, registered.
REQ-013 SHALL have port ser_txd, output, 1 bit: serial out, idle high.
REQ-014 SHALL have port ser_rxd, input, 1 bit: asynchronous serial in.
REQ-015 SHALL have port ser_ncts, input, 1 bit: asynchronous, low = peer ready.
REQ-016 SHALL have port ser_nrts, output, 1 bit: low = this block ready to receive.

Function
REQ-017 SHALL use 8N1 framing, LSB first, one bit time = divisor clocks.
REQ-018 SHALL update rd_data the cycle after rd; rd_data reads 0 when rd is low.
REQ-019 SHALL map addr 0 as follows. Write pushes wr_data[7:0] to TX. Read returns status: bit0 tx_full, bit1 tx_idle (FIFO empty and shifter idle), bit2 rx_overrun, bit3 rx_frame_err, bit4 tx_overflow.
REQ-020 SHALL map addr 1 read as: pop RX; data in [7:0]. An empty FIFO returns 0 and does not pop.
REQ-021 SHALL map addr 2 as follows. Read returns RX count in [RX_LOG2:0]. Write clears sticky flags where wr_data bits 2/3/4 are set (W1C).
REQ-022 SHALL map addr 3 as the 16-bit divisor, read/write; written values <4 SHALL be stored as 4.
REQ-023 SHALL apply a divisor write at the next frame start (TX) or start-bit detect (RX); a frame in flight keeps its old divisor.
REQ-024 SHALL drop a TX push while full and set tx_overflow.
REQ-025 SHALL keep the FIFO count unchanged on a simultaneous push and pop, including at full or empty.
REQ-026 SHALL have TX states IDLE, START, DATA(8), STOP; IDLE->START only when the TX FIFO is non-empty and, if FLOW_CTRL, synchronised ser_ncts is low.
REQ-027 SHALL, when ser_ncts deasserts mid-frame, complete the current frame; only new frames are held.
REQ-028 SHALL pass ser_rxd and ser_ncts through 2-flop synchronisers.
REQ-029 SHALL have RX states IDLE, START, DATA, STOP. A falling edge in IDLE enters START. Sample at divisor/2; high there returns to IDLE (glitch).
REQ-030 SHALL sample data and stop bits at mid-bit.
REQ-031 SHALL, if the stop bit is low, discard the byte, set rx_frame_err and wait for the line to go high before IDLE.
REQ-032 SHALL, if a valid byte arrives while the RX FIFO is full, discard it and set rx_overrun.
REQ-033 SHALL drive ser_nrts high while RX free entries <2, else low (when FLOW_CTRL=1).
REQ-034 SHALL give a sticky-flag set precedence over a W1C clear in the same cycle.

Reset
REQ-035 SHALL, on rst, set ser_txd=1, ser_nrts=1, rd_data=0, both FIFOs empty, flags 0, divisor=FREQ/BPS, FSMs IDLE.
REQ-036 SHALL, when rst is asserted mid-frame, drive ser_txd high the next cycle and abandon the frame.
REQ-037 SHALL drive ser_nrts low the cycle after rst falls (FIFO empty).

Structure
REQ-038 SHALL place register addresses, status bit indices and the minimum divisor (4) in the shared soclib package.
REQ-039 SHALL instantiate sub-module sync_fifo (parameters WIDTH, LOG2; push/pop/full/empty/count) twice.

Verification
REQ-040 SHALL cover: write 0x55 to addr 0 with divisor 16 -> ser_txd low 16 clocks, then 1,0,1,0,1,0,1,0 at 16 clocks each, then high; status bit1 = 1 after the stop bit.
REQ-041 SHALL cover: drive 0xA3 on ser_rxd at divisor 16 -> addr 2 reads 1; addr 1 reads 0xA3; addr 2 then reads 0.
REQ-042 SHALL cover: push 17 bytes into a 16-deep TX FIFO with ser_ncts high -> no TX start; tx_full=1; tx_overflow=1; ser_ncts low -> exactly 16 frames sent.
REQ-043 SHALL cover: receive 16 bytes with no pops -> ser_nrts high after byte 15; a 17th byte sets rx_overrun; W1C 0x4 to addr 2 clears it.
REQ-044 SHALL cover: stop bit forced low -> rx_frame_err=1 and RX count unchanged; a 1-clock low glitch -> no byte and no flag.
REQ-045 SHALL cover: write divisor 2 -> addr 3 reads 4; rst mid-TX-frame -> ser_txd=1 next cycle and divisor reads 347.
